// File: rtl/dac_spi_tx.sv
// Servo-loop DAC transmitter: rescales the signed controller output Yk to a 12-bit offset-binary
// code and ships it MSB-first as a 16-bit SPI frame. Define SAT_EN for saturating conversion.
module dac_spi_tx #(
  parameter int unsigned cant_bits = 16,
  parameter int unsigned FRAC_BITS = 8,
  parameter int unsigned CLK_DIV   = 4
) (
  input  logic                     Clk_G,
  input  logic                     Rst_G,
  input  logic [2*cant_bits-1:0]   Yk,
  input  logic                     Tx_Start,
  output logic                     SClk,
  output logic                     Sync_n,
  output logic                     Dout,
  output logic                     Busy,
  output logic                     Tx_Done,
  output logic                     Ovr,
  output logic                     Sat
);

  localparam int unsigned YW       = 2 * cant_bits;
  localparam logic [7:0]  HalfLast = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StShift = 3'd2,
    StGap   = 3'd3,
    StDone  = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic signed [YW-1:0]  yk_q, yk_d;
  logic [15:0]           sr_q, sr_d;
  logic [7:0]            half_q, half_d;
  logic [3:0]            bit_q, bit_d;
  logic                  sclk_q, sclk_d;
  logic                  sync_n_q, sync_n_d;
  logic                  dout_q, dout_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  ovr_q, ovr_d;
  logic [11:0]           code;

`ifdef SAT_EN
  localparam logic signed [YW-1:0] SMax = YW'(2047);
  localparam logic signed [YW-1:0] SMin = YW'(-2048);

  logic signed [YW-1:0] s;
  logic                 clip;
  logic                 sat_q;

  always_comb begin
    s    = yk_q >>> FRAC_BITS;
    code = s[11:0] ^ 12'h800;
    clip = 1'b0;
    if (s > SMax) begin
      code = 12'hFFF;
      clip = 1'b1;
    end else if (s < SMin) begin
      code = 12'h000;
      clip = 1'b1;
    end
  end

  // Sat reflects the frame launched from LOAD and holds until the next one.
  always_ff @(posedge Clk_G or posedge Rst_G) begin
    if (Rst_G) begin
      sat_q <= 1'b0;
    end else if (state_q == StLoad) begin
      sat_q <= clip;
    end
  end

  assign Sat = sat_q;
`else
  logic unused_yk;

  // Wrapping conversion: offset binary is the low 12 bits with the sign bit flipped.
  assign code      = yk_q[FRAC_BITS +: 12] ^ 12'h800;
  assign unused_yk = ^yk_q;
  assign Sat       = 1'b0;
`endif

  always_ff @(posedge Clk_G or posedge Rst_G) begin
    if (Rst_G) begin
      state_q  <= StIdle;
      yk_q     <= '0;
      sr_q     <= '0;
      half_q   <= '0;
      bit_q    <= '0;
      sclk_q   <= 1'b1;
      sync_n_q <= 1'b1;
      dout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      yk_q     <= yk_d;
      sr_q     <= sr_d;
      half_q   <= half_d;
      bit_q    <= bit_d;
      sclk_q   <= sclk_d;
      sync_n_q <= sync_n_d;
      dout_q   <= dout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ovr_q    <= ovr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    yk_d     = yk_q;
    sr_d     = sr_q;
    half_d   = half_q;
    bit_d    = bit_q;
    sclk_d   = sclk_q;
    sync_n_d = sync_n_q;
    dout_d   = dout_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    ovr_d    = Tx_Start && (state_q != StIdle);

    case (state_q)
      StIdle: begin
        if (Tx_Start) begin
          yk_d    = Yk;
          busy_d  = 1'b1;
          state_d = StLoad;
        end
      end

      StLoad: begin
        sr_d     = {4'b0000, code};
        dout_d   = sr_d[15];
        sync_n_d = 1'b0;
        sclk_d   = 1'b1;
        half_d   = '0;
        bit_d    = '0;
        state_d  = StShift;
      end

      StShift: begin
        if (half_q == HalfLast) begin
          half_d = '0;
          if (sclk_q) begin
            sclk_d = 1'b0;
          end else if (bit_q == 4'd15) begin
            sclk_d   = 1'b1;
            sync_n_d = 1'b1;
            dout_d   = 1'b0;
            state_d  = StGap;
          end else begin
            // Rising edge: advance to the next bit, sampled at the following fall.
            sclk_d = 1'b1;
            sr_d   = {sr_q[14:0], 1'b0};
            dout_d = sr_q[14];
            bit_d  = bit_q + 4'd1;
          end
        end else begin
          half_d = half_q + 8'd1;
        end
      end

      StGap: begin
        if (half_q == HalfLast) begin
          half_d  = '0;
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          half_d = half_q + 8'd1;
        end
      end

      StDone: begin
        busy_d  = 1'b0;
        bit_d   = '0;
        state_d = StIdle;
      end

      default: begin
        state_d  = StIdle;
        half_d   = '0;
        bit_d    = '0;
        sclk_d   = 1'b1;
        sync_n_d = 1'b1;
        dout_d   = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  assign SClk    = sclk_q;
  assign Sync_n  = sync_n_q;
  assign Dout    = dout_q;
  assign Busy    = busy_q;
  assign Tx_Done = done_q;
  assign Ovr     = ovr_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: directed and random frames decoded from the SPI pins and compared with
// an arithmetic model of the Yk-to-code conversion and frame timing.
module tb_dac_spi_tx;

  localparam int ClkDiv   = 4;
  localparam int FracBits = 8;

  logic        Clk_G = 1'b0;
  logic        Rst_G = 1'b1;
  logic [31:0] Yk = '0;
  logic        Tx_Start = 1'b0;
  logic        SClk, Sync_n, Dout, Busy, Tx_Done, Ovr, Sat;

  int total = 0;
  int bad   = 0;

  dac_spi_tx #(
    .cant_bits(16),
    .FRAC_BITS(FracBits),
    .CLK_DIV  (ClkDiv)
  ) dut (
    .Clk_G   (Clk_G),
    .Rst_G   (Rst_G),
    .Yk      (Yk),
    .Tx_Start(Tx_Start),
    .SClk    (SClk),
    .Sync_n  (Sync_n),
    .Dout    (Dout),
    .Busy    (Busy),
    .Tx_Done (Tx_Done),
    .Ovr     (Ovr),
    .Sat     (Sat)
  );

  always #5 Clk_G = ~Clk_G;

  task automatic tick();
    @(posedge Clk_G);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {sat, frame}: floor-divide by 2^FracBits, optionally clamp, then add the 2048 offset mod 4096.
  function automatic logic [16:0] model(input logic [31:0] y);
    longint s;
    logic   sat;
    s   = longint'($signed(y)) >>> FracBits;
    sat = 1'b0;
`ifdef SAT_EN
    if (s > 2047) begin
      s   = 2047;
      sat = 1'b1;
    end else if (s < -2048) begin
      s   = -2048;
      sat = 1'b1;
    end
`endif
    s = (s + 2048) % 4096;
    if (s < 0) s = s + 4096;
    return {sat, 4'b0000, 12'(s)};
  endfunction

  // Sends one frame and decodes the pins; ovr_at > 0 fires a second Tx_Start after sample ovr_at.
  task automatic send_frame(input logic [31:0] y, input int ovr_at, input string tag);
    logic [16:0] m;
    logic [15:0] word;
    int   falls, first_fall, sf, sr, dn, dc, bl, on, oc, last_chg, last_fall, sync_falls;
    logic p_sclk, p_sync, p_dout, stab_ok, sat1;
    m = model(y);
    word = '0;
    falls = 0; sync_falls = 0; dc = 0; oc = 0;
    first_fall = -1; sf = -1; sr = -1; dn = -1; bl = -1; on = -1;
    last_chg = -100; last_fall = -100;
    stab_ok = 1'b1; sat1 = 1'b0;

    Yk = y; Tx_Start = 1'b1;
    tick();
    Tx_Start = 1'b0;
    Yk = $urandom;
    chk({tag, ":busy_e0"}, 32'(Busy), 1);
    p_sclk = SClk; p_sync = Sync_n; p_dout = Dout;

    for (int n = 1; n <= 160; n++) begin
      tick();
      if (p_sync && !Sync_n) begin
        sync_falls++;
        if (sf < 0) sf = n;
        last_chg = n;
      end
      if (!p_sync && Sync_n && sr < 0) sr = n;
      if (!Sync_n && p_sclk && !SClk) begin
        falls++;
        word = {word[14:0], Dout};
        if (first_fall < 0) first_fall = n;
        if (n - last_chg < ClkDiv) stab_ok = 1'b0;
        last_fall = n;
      end
      if (Dout != p_dout) begin
        if (n - last_fall < ClkDiv) stab_ok = 1'b0;
        last_chg = n;
      end
      if (Tx_Done) begin
        dc++;
        if (dn < 0) dn = n;
      end
      if (!Busy && bl < 0) bl = n;
      if (Ovr) begin
        oc++;
        if (on < 0) on = n;
      end
      if (n == 1) sat1 = Sat;
      p_sclk = SClk; p_sync = Sync_n; p_dout = Dout;
      Tx_Start = (n == ovr_at);
      if (n == ovr_at) Yk = $urandom;
    end
    Tx_Start = 1'b0;

    chk({tag, ":frame"},      32'(word), 32'(m[15:0]));
    chk({tag, ":sclk_falls"}, falls, 16);
    chk({tag, ":first_fall"}, first_fall, 1 + ClkDiv);
    chk({tag, ":sync_fall"},  sf, 1);
    chk({tag, ":sync_low"},   sr - sf, 32 * ClkDiv);
    chk({tag, ":sync_once"},  sync_falls, 1);
    chk({tag, ":done_at"},    dn, 1 + 33 * ClkDiv);
    chk({tag, ":done_cnt"},   dc, 1);
    chk({tag, ":busy_low"},   bl, 2 + 33 * ClkDiv);
    chk({tag, ":dout_stab"},  32'(stab_ok), 1);
    chk({tag, ":sat_e1"},     32'(sat1), 32'(m[16]));
    chk({tag, ":sat_hold"},   32'(Sat), 32'(m[16]));
    chk({tag, ":ovr_cnt"},    oc, (ovr_at > 0) ? 1 : 0);
    if (ovr_at > 0) chk({tag, ":ovr_at"}, on, ovr_at + 1);
    chk({tag, ":idle_sync"},  32'(Sync_n), 1);
  endtask

  initial begin
    int dc;
    int sync_low;
    logic [31:0] y;

    Rst_G = 1'b1;
    tick();
    chk("rst_sclk", 32'(SClk), 1);
    chk("rst_sync", 32'(Sync_n), 1);
    chk("rst_dout", 32'(Dout), 0);
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_done", 32'(Tx_Done), 0);
    chk("rst_ovr",  32'(Ovr), 0);
    chk("rst_sat",  32'(Sat), 0);
    tick();
    Rst_G = 1'b0;
    repeat (3) tick();

    send_frame(32'h0000_0000, 0, "zero");
    send_frame(32'h0001_0000, 0, "p256");
    send_frame(32'hFFFF_FFFF, 0, "m1");
    send_frame(32'h7FFF_FFFF, 0, "maxpos");
    send_frame(32'h8000_0000, 0, "maxneg");
    send_frame(32'h0003_4500, 50, "ovr_mid");
    send_frame(32'hFFFA_1200, 133, "ovr_done");

    // Mid-frame asynchronous reset.
    Yk = 32'h0002_3400; Tx_Start = 1'b1;
    tick();
    Tx_Start = 1'b0;
    repeat (70) tick();
    Rst_G = 1'b1;
    #1;
    chk("arst_sclk", 32'(SClk), 1);
    chk("arst_sync", 32'(Sync_n), 1);
    chk("arst_dout", 32'(Dout), 0);
    chk("arst_busy", 32'(Busy), 0);
    tick();
    tick();
    Rst_G = 1'b0;
    dc = 0; sync_low = 0;
    for (int n = 0; n < 150; n++) begin
      tick();
      if (Tx_Done) dc++;
      if (!Sync_n) sync_low++;
    end
    chk("arst_no_done", dc, 0);
    chk("arst_idle",    sync_low, 0);
    chk("arst_busy_after", 32'(Busy), 0);
    send_frame(32'h0002_3400, 0, "after_rst");

    for (int i = 0; i < 8; i++) begin
      y = $urandom;
      if (i % 2 == 0) y = 32'($urandom_range(0, 32'h000F_FFFF)) - 32'h0008_0000;
      send_frame(y, 0, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dac_spi_tx.md
# dac_spi_tx

- Output-side transmitter of the servo loop.
- Captures the signed 2·N-bit controller output Yk on a load strobe and rescales it to a 12-bit offset-binary DAC code.
- Serialises the code MSB-first as a 16-bit SPI frame (Sync_n / SClk / Dout) to the drive DAC.
- Sits between the control-law block and the external DAC, mirroring the ADC receiver that feeds Pot with Rx_En.

## Interface

**Parameters**

- cant_bits, 16 — controller word width; Yk is 2*cant_bits wide.
- FRAC_BITS, 8 — fractional bits of Yk, discarded by arithmetic right shift.
- CLK_DIV, 4 — Clk_G cycles per SClk half-period; legal range 1..255.

**Ports**

- Clk_G  in  1  system clock
- Rst_G  in  1  reset; asynchronous, active-high
- Yk  in  2*cant_bits  signed controller output
- Tx_Start  in  1  single-cycle request to send the current Yk
- SClk  out  1  SPI clock; idles high
- Sync_n  out  1  frame select; active low
- Dout  out  1  serial data, MSB first
- Busy  out  1  frame in progress
- Tx_Done  out  1  one-cycle pulse when the frame is complete
- Ovr  out  1  one-cycle pulse when Tx_Start is dropped because Busy
- Sat  out  1  last frame clipped (sticky until next load)

## Operation

**Reset values:** SClk=1, Sync_n=1, Dout=0, Busy=0, Tx_Done=0, Ovr=0, Sat=0, FSM=IDLE, counters=0.

**Conversion, performed in LOAD:**
- s = Yk >>> FRAC_BITS (sign-preserving).
- code = s' + 2048 (offset binary), where s' is s saturated or wrapped (see Configuration).
- frame = {4'b0000, code[11:0]}; the upper nibble is the DAC normal-mode control field.

**FSM states and transitions:**
- IDLE: if Tx_Start, latch Yk and go to LOAD; Busy goes 1 at the same edge.
- LOAD: compute the frame into the 16-bit shift register. Go to SHIFT with Sync_n=0, SClk=1, Dout=frame[15].
- SHIFT: a half-period counter counts CLK_DIV cycles per SClk phase.
  - At the end of each high phase, SClk falls; the DAC samples on this edge.
  - At the end of each low phase, SClk rises and the next bit is presented on Dout.
  - After the 16th low phase, SClk returns high, Sync_n goes 1, Dout goes 0, and the FSM enters GAP.
- GAP: hold Sync_n high for CLK_DIV cycles, then go to DONE.
- DONE: Tx_Done=1 for one cycle, then IDLE; Busy goes 0 at the same edge.

**Boundary conditions:**
- Tx_Start in any state other than IDLE:
  - Ignored; Yk is not re-latched.
  - Ovr pulses one cycle.
  - The frame in progress is unaffected.
- Tx_Start in the DONE cycle: also dropped with Ovr. It is accepted from IDLE only.
- Yk changing after capture has no effect on the frame in flight.
- Rst_G asserted mid-frame:
  - All outputs return to their reset values immediately (asynchronously).
  - The frame is aborted, with no Tx_Done.
  - After release, the FSM sits in IDLE.
- Illegal FSM encodings go to IDLE with outputs at idle levels.

## Timing

- Edge E0 samples Tx_Start in IDLE.
- At E1, Sync_n falls and Dout = bit15.
- Sync_n stays low for exactly 32*CLK_DIV cycles, which is 128 at the default.
- SClk shows 16 falling edges inside the Sync_n window.
  - The first falling edge comes CLK_DIV cycles after Sync_n falls.
  - Dout is stable for at least CLK_DIV cycles on either side of each falling edge.
- Tx_Done is high in the cycle that starts CLK_DIV cycles after Sync_n rises.
  - Tx_Done rises at E(1 + 33*CLK_DIV), which is E133 at the default.
- Busy is high from E0 until the end of the Tx_Done cycle.
- Minimum Tx_Start-to-Tx_Start period for no overrun: 33*CLK_DIV + 2 cycles.
- Sat updates at E1 and holds until the next accepted frame.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration

**SAT_EN**
- Defined:
  - s' = min(max(s, -2048), 2047).
  - Sat is set to 1 if clipping occurred, else 0.
- Undefined:
  - s' = s[11:0] (two's-complement wrap), so code = s[11:0] ^ 12'h800.
  - Sat is tied to 0 and no comparator logic is built.

## Test plan

All scenarios use default parameters.

- Yk=0, Tx_Start pulse -> frame 0x0800 sampled on 16 SClk falling edges; Sync_n low 128 cycles; Tx_Done at E133; Sat=0.
- Yk=0x00010000 -> s=256 -> frame 0x0900.
- Yk=0xFFFFFFFF -> s=-1 -> frame 0x07FF.
- Yk=0x7FFFFFFF:
  - SAT_EN defined -> frame 0x0FFF, Sat=1.
  - SAT_EN undefined -> frame 0x07FF, Sat=0.
- Yk=0x80000000 with SAT_EN -> frame 0x0000, Sat=1.
- Tx_Start at E0, again at E50 with a different Yk -> Ovr pulse at E51; the frame still carries the E0 value; only one Tx_Done.
- Rst_G pulsed at E70 mid-frame -> SClk=1, Sync_n=1, Dout=0, Busy=0 immediately; no Tx_Done; a new Tx_Start after release sends a full correct frame.
